ram_banked: RTL
===============

# ram_banked

Parametrised, lane-banked, true dual-port scratchpad for the TPU datapath. It is the successor to the fixed 16×8-bit, 1024-deep buffer RAM. It adds:
- per-port request/valid handshakes;
- deterministic same-address collision resolution with write forwarding;
- a collision counter;
- a hardware clear sequencer that zeroes every word without host writes.

It sits between the input/weight loaders and the systolic array feeders.

## Interface
- `NUM_LANES`, 16, number of independent byte lanes (banks) per word
- `DWIDTH`, 8, bits per lane
- `AWIDTH`, 10, address width; depth is `1<<AWIDTH` words
- `CNT_WIDTH`, 16, collision counter width

Ports (clock and reset first):
- `clk`  in  1  single clock, all logic rising-edge
- `resetn`  in  1  asynchronous, active-low reset
- `clear_start`  in  1  pulse; starts a zero-fill of the whole array
- `clear_busy`  out  1  high while the zero-fill runs
- `a_req` / `b_req`  in  1  port request
- `a_ready` / `b_ready`  out  1  port can accept; low during clear
- `a_addr` / `b_addr`  in  AWIDTH  word address
- `a_we` / `b_we`  in  NUM_LANES  per-lane write enable; all-zero means read
- `a_wdata` / `b_wdata`  in  NUM_LANES*DWIDTH  write data, lane i at `[i*DWIDTH +: DWIDTH]`
- `a_rvalid` / `b_rvalid`  out  1  read data valid, one-cycle pulse per accepted read
- `a_rdata` / `b_rdata`  out  NUM_LANES*DWIDTH  read data; holds its last value when rvalid is low
- `coll_cnt`  out  CNT_WIDTH  saturating count of same-address collisions

## Operation
- Acceptance: a request is accepted when `req && ready`.
  - A write accepts when any `we` bit is set; only enabled lanes are written.
  - A read accepts when `we` is all-zero.
  - Writes produce no rvalid.
- FSM states:
  - IDLE → CLEAR on `clear_start`.
  - CLEAR → IDLE after writing address `(1<<AWIDTH)-1`.
  - `clear_start` is ignored while in CLEAR.
- CLEAR behaviour:
  - The address counter starts at 0 and increments each cycle.
  - Every cycle, all lanes are written with zero through port A.
  - `a_ready` and `b_ready` are low; pending reads still complete.
- Write/write collision (both accepted, same address): port A wins on lanes enabled by both ports; lanes enabled by only one port take that port's data.
- Read/write collision (same address): the reading port receives the newly written data on written lanes and the stored data on the others (write-first forwarding). In a collision where both ports write, forwarding uses the resolved data.
- Read/read, same address: both ports return identical data.
- `coll_cnt`:
  - Increments by 1 when both ports are accepted in the same cycle at the same address and at least one of them writes.
  - Saturates at all-ones.
  - Clears to 0 on `clear_start` accepted in IDLE.
- Reset: FSM to IDLE, clear counter to 0, `clear_busy`=0, `*_rvalid`=0, `*_rdata`=0, `coll_cnt`=0, `*_ready`=1 from the first cycle after release. Memory contents are not reset.
- Reset during CLEAR aborts the sweep; the array is left partially cleared.

## Timing
- Read latency: request accepted in cycle N → `rvalid`/`rdata` in cycle N+1. With `RAM_OUT_REG_EN`, the response is in cycle N+2.
- Back-to-back reads on a port give one rvalid per cycle, in order.
- Clear timing:
  - `clear_start` sampled in cycle N.
  - `clear_busy` and `!ready` from N+1 through N+(1<<AWIDTH).
  - Ready again at N+(1<<AWIDTH)+1.
- Write to address X in cycle N, read X on the same port in N+1: returns the new data.

## Configuration
- `RAM_OUT_REG_EN`:
  - Defined: adds an output register stage on `rdata` and `rvalid` for both ports; read latency is 2; forwarding and collision semantics are unchanged.
  - Undefined: read latency is 1, with data taken directly from the lane arrays plus the forwarding mux.

## Structure
- Package `ram_pkg` holds:
  - the FSM state enum (`RAM_IDLE`, `RAM_CLEAR`);
  - the lane-slice helper constant;
  - default parameter values.
- Sub-module `dpram_lane`: one DWIDTH × `1<<AWIDTH` true dual-port array with per-port write enable. It is instantiated NUM_LANES times in a generate loop; collision and forwarding logic stay in `ram_banked`.

## Test plan
- Lane-masked write and read: A writes `addr=5`, `we=16'h00FF`, data lanes = lane index. A then reads 5 → lanes 0–7 = 0..7, lanes 8–15 = prior contents; rvalid exactly 1 cycle after the read.
- Write/write collision: A and B both write `addr=9`. A uses `we=16'h000F`, data all `0xAA`; B uses `we=16'h00FF`, data all `0x55`.
  - Reading 9 gives lanes 0–3=`0xAA`, lanes 4–7=`0x55`.
  - `coll_cnt`=1.
- Read/write forwarding: A writes `addr=3` all lanes `0x7E` while B reads `addr=3` in the same cycle → `b_rdata` all `0x7E`; `coll_cnt` increments.
- Clear sweep (AWIDTH=4 instance): fill all 16 words with `0xFF`, then pulse `clear_start`.
  - `clear_busy` is high for 16 cycles and ready is low throughout.
  - Afterwards every word reads 0 and `coll_cnt`=0.
- Reset mid-clear: assert `resetn`=0 at sweep address 7 → outputs return to reset values, words 0–6 read 0, words ≥8 keep `0xFF`.
- Counter saturation (CNT_WIDTH=4): issue 20 colliding writes → `coll_cnt` stays at 15.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared types and defaults for the lane-banked scratchpad (ram_banked / dpram_lane).
package ram_pkg;

    localparam int unsigned RAM_NUM_LANES = 16;
    localparam int unsigned RAM_DWIDTH    = 8;
    localparam int unsigned RAM_AWIDTH    = 10;
    localparam int unsigned RAM_CNT_WIDTH = 16;

    typedef enum logic {
        RAM_IDLE  = 1'b0,
        RAM_CLEAR = 1'b1
    } ram_state_e;

    // Bit offset of lane `lane` within a packed word of `dwidth`-bit lanes.
    function automatic int unsigned lane_lo(input int unsigned lane, input int unsigned dwidth);
        return lane * dwidth;
    endfunction

endpackage

// File: rtl/dpram_lane.sv
// One byte-lane bank: DWIDTH x (1<<AWIDTH) true dual-port array with registered reads.
// Port A is written after port B, so A owns any lane both ports write in the same cycle.
module dpram_lane #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 10
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              a_en,
    input  logic              a_we,
    input  logic [AWIDTH-1:0] a_addr,
    input  logic [DWIDTH-1:0] a_wdata,
    output logic [DWIDTH-1:0] a_rdata,
    input  logic              b_en,
    input  logic              b_we,
    input  logic [AWIDTH-1:0] b_addr,
    input  logic [DWIDTH-1:0] b_wdata,
    output logic [DWIDTH-1:0] b_rdata
);

    localparam int unsigned DEPTH = 1 << AWIDTH;

    logic [DWIDTH-1:0] mem [DEPTH];
    logic [DWIDTH-1:0] a_rdata_q;
    logic [DWIDTH-1:0] b_rdata_q;

    // Contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
        if (a_we) begin
            mem[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            if (a_en) begin
                a_rdata_q <= mem[a_addr];
            end
            if (b_en) begin
                b_rdata_q <= mem[b_addr];
            end
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/ram_banked.sv
// Lane-banked true dual-port scratchpad with write-first forwarding, collision counter and
// hardware zero-fill. Define RAM_OUT_REG_EN to add an output register stage (read latency 2).
module ram_banked
    import ram_pkg::*;
#(
    parameter int unsigned NUM_LANES = RAM_NUM_LANES,
    parameter int unsigned DWIDTH    = RAM_DWIDTH,
    parameter int unsigned AWIDTH    = RAM_AWIDTH,
    parameter int unsigned CNT_WIDTH = RAM_CNT_WIDTH
) (
    input  logic                        clk,
    input  logic                        resetn,
    input  logic                        clear_start,
    output logic                        clear_busy,
    input  logic                        a_req,
    output logic                        a_ready,
    input  logic [AWIDTH-1:0]           a_addr,
    input  logic [NUM_LANES-1:0]        a_we,
    input  logic [NUM_LANES*DWIDTH-1:0] a_wdata,
    output logic                        a_rvalid,
    output logic [NUM_LANES*DWIDTH-1:0] a_rdata,
    input  logic                        b_req,
    output logic                        b_ready,
    input  logic [AWIDTH-1:0]           b_addr,
    input  logic [NUM_LANES-1:0]        b_we,
    input  logic [NUM_LANES*DWIDTH-1:0] b_wdata,
    output logic                        b_rvalid,
    output logic [NUM_LANES*DWIDTH-1:0] b_rdata,
    output logic [CNT_WIDTH-1:0]        coll_cnt
);

    localparam int unsigned W = NUM_LANES * DWIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = 1;
    localparam logic [AWIDTH-1:0]    ADDR_ONE = 1;

    ram_state_e           state_q;
    logic [AWIDTH-1:0]    clr_addr_q;
    logic                 clear_busy_q;
    logic [CNT_WIDTH-1:0] coll_cnt_q;

    logic a_acc, b_acc, a_wr, b_wr, a_rd, b_rd, same_addr, coll;

    assign a_ready   = ~clear_busy_q;
    assign b_ready   = ~clear_busy_q;
    assign a_acc     = a_req & a_ready;
    assign b_acc     = b_req & b_ready;
    assign a_wr      = a_acc & (|a_we);
    assign b_wr      = b_acc & (|b_we);
    assign a_rd      = a_acc & ~(|a_we);
    assign b_rd      = b_acc & ~(|b_we);
    assign same_addr = (a_addr == b_addr);
    assign coll      = a_acc & b_acc & same_addr & (a_wr | b_wr);

    // Clear sequencer and collision counter.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= RAM_IDLE;
            clr_addr_q   <= '0;
            clear_busy_q <= 1'b0;
            coll_cnt_q   <= '0;
        end else begin
            unique case (state_q)
                RAM_IDLE: begin
                    if (clear_start) begin
                        state_q      <= RAM_CLEAR;
                        clr_addr_q   <= '0;
                        clear_busy_q <= 1'b1;
                        coll_cnt_q   <= '0;
                    end else if (coll && (coll_cnt_q != '1)) begin
                        coll_cnt_q <= coll_cnt_q + CNT_ONE;
                    end
                end
                RAM_CLEAR: begin
                    if (clr_addr_q == '1) begin
                        state_q      <= RAM_IDLE;
                        clear_busy_q <= 1'b0;
                    end
                    clr_addr_q <= clr_addr_q + ADDR_ONE;
                end
                default: begin
                    state_q      <= RAM_IDLE;
                    clear_busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign clear_busy = clear_busy_q;
    assign coll_cnt   = coll_cnt_q;

    // Port A of the banks is borrowed by the sequencer while clearing.
    logic [AWIDTH-1:0]    ma_addr;
    logic [NUM_LANES-1:0] ma_we;
    logic [W-1:0]         ma_wdata;
    logic [NUM_LANES-1:0] mb_we;

    always_comb begin
        ma_addr  = a_addr;
        ma_we    = a_wr ? a_we : '0;
        ma_wdata = a_wdata;
        if (clear_busy_q) begin
            ma_addr  = clr_addr_q;
            ma_we    = '1;
            ma_wdata = '0;
        end
    end

    always_comb begin
        mb_we = '0;
        if (b_wr) begin
            mb_we = (a_wr && same_addr) ? (b_we & ~a_we) : b_we;
        end
    end

    // Forwarding state captured with each accepted read, so rdata holds between reads.
    logic [NUM_LANES-1:0] a_fwd_mask_q, b_fwd_mask_q;
    logic [W-1:0]         a_fwd_data_q, b_fwd_data_q;
    logic                 a_rvalid1_q, b_rvalid1_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_fwd_mask_q <= '0;
            b_fwd_mask_q <= '0;
            a_fwd_data_q <= '0;
            b_fwd_data_q <= '0;
            a_rvalid1_q  <= 1'b0;
            b_rvalid1_q  <= 1'b0;
        end else begin
            a_rvalid1_q <= a_rd;
            b_rvalid1_q <= b_rd;
            if (a_rd) begin
                a_fwd_mask_q <= (b_wr && same_addr) ? mb_we : '0;
                a_fwd_data_q <= b_wdata;
            end
            if (b_rd) begin
                b_fwd_mask_q <= (a_wr && same_addr) ? a_we : '0;
                b_fwd_data_q <= a_wdata;
            end
        end
    end

    logic [W-1:0] a_lane_rdata, b_lane_rdata;
    logic [W-1:0] a_rdata1, b_rdata1;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam int unsigned LO = lane_lo(i, DWIDTH);

        dpram_lane #(
            .DWIDTH (DWIDTH),
            .AWIDTH (AWIDTH)
        ) u_lane (
            .clk     (clk),
            .resetn  (resetn),
            .a_en    (a_rd),
            .a_we    (ma_we[i]),
            .a_addr  (ma_addr),
            .a_wdata (ma_wdata[LO +: DWIDTH]),
            .a_rdata (a_lane_rdata[LO +: DWIDTH]),
            .b_en    (b_rd),
            .b_we    (mb_we[i]),
            .b_addr  (b_addr),
            .b_wdata (b_wdata[LO +: DWIDTH]),
            .b_rdata (b_lane_rdata[LO +: DWIDTH])
        );

        assign a_rdata1[LO +: DWIDTH] = a_fwd_mask_q[i] ? a_fwd_data_q[LO +: DWIDTH]
                                                        : a_lane_rdata[LO +: DWIDTH];
        assign b_rdata1[LO +: DWIDTH] = b_fwd_mask_q[i] ? b_fwd_data_q[LO +: DWIDTH]
                                                        : b_lane_rdata[LO +: DWIDTH];
    end

`ifdef RAM_OUT_REG_EN
    logic [W-1:0] a_rdata2_q, b_rdata2_q;
    logic         a_rvalid2_q, b_rvalid2_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_rdata2_q  <= '0;
            b_rdata2_q  <= '0;
            a_rvalid2_q <= 1'b0;
            b_rvalid2_q <= 1'b0;
        end else begin
            a_rvalid2_q <= a_rvalid1_q;
            b_rvalid2_q <= b_rvalid1_q;
            if (a_rvalid1_q) begin
                a_rdata2_q <= a_rdata1;
            end
            if (b_rvalid1_q) begin
                b_rdata2_q <= b_rdata1;
            end
        end
    end

    assign a_rvalid = a_rvalid2_q;
    assign b_rvalid = b_rvalid2_q;
    assign a_rdata  = a_rdata2_q;
    assign b_rdata  = b_rdata2_q;
`else
    assign a_rvalid = a_rvalid1_q;
    assign b_rvalid = b_rvalid1_q;
    assign a_rdata  = a_rdata1;
    assign b_rdata  = b_rdata1;
`endif

endmodule
